// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, word-length codes and parity helpers.
// Used by both the transmit controller and the baud counter.
package uart_pkg;

  localparam int DEF_DIV_W = 16;

  localparam logic TX_IDLE = 1'b1;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Keeps only the data bits inside the configured word length.
  function automatic logic [7:0] wlen_mask(input logic [1:0] wlen);
    return 8'hFF >> (2'd3 - wlen);
  endfunction

  function automatic logic par_bit(input logic [7:0] data, input logic [1:0] wlen,
                                   input logic even, input logic stick);
    if (stick) return ~even;
    return (^(data & wlen_mask(wlen))) ^ ~even;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter; tick marks the last cycle of a bit.
// Reloads itself from div on tick so consecutive bits need no extra load.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (load || r_cnt == '0)
      r_cnt <= div;
    else
      r_cnt <= r_cnt - DIV_W'(1);
  end

  assign tick = (r_cnt == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop.
// Line config is shadowed at byte acceptance; break gates the pin only.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       wlen,
  input  logic             stop2,
  input  logic             par_en,
  input  logic             par_even,
  input  logic             par_stick,
  input  logic             brk,
  input  logic [7:0]       thr_data,
  input  logic             thr_valid,
  output logic             thr_ready,
  output logic             tx,
  output logic             busy,
  output logic             thre_pulse
);

  tx_state_e        r_state;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit_idx;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_wlen;
  logic             r_stop2;
  logic             r_par_en;
  logic             r_par_bit;
  logic             r_stop_2nd;
  logic             r_fsm_tx;
  logic             r_busy;
  logic             r_thr_ready;

  logic             w_accept;
  logic             w_tick;
  logic             w_last_bit;
  logic [DIV_W-1:0] w_cnt_div;

  assign w_accept   = thr_valid & r_thr_ready & (r_state == IDLE);
  // Live divisor only on the load cycle; afterwards the shadow copy drives reloads.
  assign w_cnt_div  = w_accept ? div : r_div;
  assign w_last_bit = (r_bit_idx == ({1'b0, r_wlen} + 3'd4));

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_accept),
    .div   (w_cnt_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_div       <= '0;
      r_wlen      <= '0;
      r_stop2     <= 1'b0;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_2nd  <= 1'b0;
      r_fsm_tx    <= TX_IDLE;
      r_busy      <= 1'b0;
      r_thr_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_fsm_tx    <= TX_IDLE;
          r_busy      <= 1'b0;
          r_thr_ready <= 1'b1;
          if (w_accept) begin
            r_shift     <= thr_data;
            r_div       <= div;
            r_wlen      <= wlen;
            r_stop2     <= stop2;
            r_par_en    <= par_en;
            r_par_bit   <= par_bit(thr_data, wlen, par_even, par_stick);
            r_bit_idx   <= '0;
            r_stop_2nd  <= 1'b0;
            r_fsm_tx    <= 1'b0;
            r_busy      <= 1'b1;
            r_thr_ready <= 1'b0;
            r_state     <= START;
          end
        end
        START: begin
          if (w_tick) begin
            r_fsm_tx <= r_shift[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_tick) begin
            r_shift   <= {1'b0, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (!w_last_bit) begin
              r_fsm_tx <= r_shift[1];
            end else if (r_par_en) begin
              r_fsm_tx <= r_par_bit;
              r_state  <= PARITY;
            end else begin
              r_fsm_tx <= TX_IDLE;
              r_state  <= STOP;
            end
          end
        end
        PARITY: begin
          if (w_tick) begin
            r_fsm_tx <= TX_IDLE;
            r_state  <= STOP;
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_stop2 && !r_stop_2nd) begin
              r_stop_2nd <= 1'b1;
            end else begin
              r_busy      <= 1'b0;
              r_thr_ready <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
        default: begin
          r_fsm_tx    <= TX_IDLE;
          r_busy      <= 1'b0;
          r_thr_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign tx         = r_fsm_tx & ~brk;
  assign busy       = r_busy;
  assign thr_ready  = r_thr_ready;
  assign thre_pulse = w_accept;

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame sequencer for the UART transmit path. Accepts a byte from the transmit holding register over a valid/ready handshake and generates the bit-period timing from a programmable divisor. It sequences start, data (LSB first), optional parity and stop bits onto `tx`. It sits between the register/bus side (THR, LCR-style line configuration, divisor latch) and the serial pin, and replaces free-running bit-rate clocking with a single system clock.

## Interface
- `DIV_W`, 16, width of the baud divisor.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `div`  in  DIV_W  bit period minus one, in `clk` cycles; sampled at frame load; 0 gives a 1-cycle bit.
- `wlen`  in  2  data length = 5 + `wlen` (00:5 … 11:8); sampled at load.
- `stop2`  in  1  1 = two stop bits, 0 = one; sampled at load.
- `par_en`  in  1  parity bit enable; sampled at load.
- `par_even`  in  1  1 = even, 0 = odd; sampled at load.
- `par_stick`  in  1  stick parity: bit = ~`par_even`; sampled at load.
- `brk`  in  1  break: forces `tx` low while high; live, not sampled.
- `thr_data`  in  8  byte to send; bits above the word length are ignored.
- `thr_valid`  in  1  `thr_data` is valid.
- `thr_ready`  out  1  controller can accept a byte this cycle.
- `tx`  out  1  serial output, idle high.
- `busy`  out  1  frame in progress (any state but IDLE).
- `thre_pulse`  out  1  one-cycle pulse on the cycle a byte is accepted (THR empty event).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1, `thr_ready`=1. When `thr_valid`&&`thr_ready`:
  - latch the byte into the shift register;
  - latch the config into shadow registers;
  - load the bit counter with `div`;
  - pulse `thre_pulse`;
  - go to START.
- START: `tx`=0 for div+1 cycles, then DATA.
- DATA: `tx` = shift[0]. At the end of each bit, shift right and increment the bit index. After 5+`wlen` bits go to PARITY if `par_en`, else STOP.
- PARITY: `tx` = parity bit for div+1 cycles, then STOP.
  - Normal: parity bit = XOR(data bits within word length) ^ ~`par_even`, so even gives an even total count of ones.
  - Stick: parity bit = ~`par_even`.
- STOP: `tx`=1 for (div+1)×(1+`stop2`) cycles, then IDLE.
- Output gating: `tx` = fsm_tx & ~`brk`. Break never stalls or alters FSM progress.
- Config changes mid-frame have no effect until the next load. `thr_valid` outside IDLE is ignored; the data is held upstream.
- Bit counter: down-counter of width DIV_W. The end of a bit is count==0, which reloads `div`. Never wraps past 0.

## Timing
- Reset (rst_n low at a clock edge):
  - state IDLE;
  - `tx`=1, `busy`=0, `thre_pulse`=0;
  - shift register and shadow config all zero;
  - `thr_ready` is 0 while `rst_n` is low and 1 on the first cycle after release.
- Reset mid-frame aborts it: `tx`=1 from the next cycle. No partial stop bit is sent.
- Acceptance cycle (IDLE, handshake): `tx` still 1. Start bit begins on the next cycle.
- Frame length in cycles: (div+1)×(1 + (5+wlen) + par_en + 1 + stop2).
- `busy` rises the cycle after acceptance and falls on the first IDLE cycle.
- `thr_ready` is registered-state driven: high only in IDLE. Back-to-back frames are therefore separated by exactly one idle-high cycle.
- `thre_pulse` is coincident with the accepting handshake edge and is never asserted in the same cycle twice.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum;
  - `WLEN_5`..`WLEN_8` encodings;
  - `DIV_W` default;
  - `TX_IDLE` = 1'b1.
- Sub-module `uart_baud_cnt`: loadable down-counter.
  - Inputs: `clk`, `rst_n`, `load`, `div`.
  - Output: `tick` when the count is 0.
  - Also reusable by the receive path.

## Test plan
- 8N1, div=3, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `busy` high 40 cycles; one `thre_pulse`.
- 7E1, div=1, send 0x41 → data 1,0,0,0,0,0,1, parity 0, stop 1. With `par_even`=0 the parity bit is 1. Frame is 20 cycles.
- 5-bit, stick parity with `par_even`=0, stop2, div=0, send 0xFF → 0,1,1,1,1,1,1,1,1 (stick bit 1, two stops), 9 cycles; upper bits of 0xFF ignored.
- `thr_valid` held with 0x12 then 0x34, 8N1, div=0 → two 10-cycle frames separated by exactly one idle-high cycle; two `thre_pulse`s 11 cycles apart.
- `rst_n` low for one cycle during data bit 3 → `tx`=1 next cycle, `busy`=0, `thr_ready`=1 one cycle after release; the next byte is sent cleanly.
- `brk` asserted for 15 cycles mid-frame (8N1, div=3) → `tx`=0 throughout. The FSM finishes on schedule: `busy` falls at cycle 40 unchanged.
